// File: rtl/ibpl_pkg.sv
// Shared types and sizing helpers for the interbackplane output cardlet.
package ibpl_pkg;

    localparam int unsigned IBPL_NUM_CH = 6;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } chan_state_t;

    // Bits needed to hold the values 0..n-1, never fewer than one.
    function automatic int unsigned ibpl_cw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ibpl_out_chan.sv
// One DIOB output channel: driver turn-on/turn-off sequencing, pulse stretching,
// readback supervision with sticky fault, and activity LED timer.
module ibpl_out_chan
    import ibpl_pkg::*;
#(
    parameter int unsigned TURN_CYC  = 4,
    parameter int unsigned MIN_PULSE = 8,
    parameter int unsigned FB_CYC    = 16,
    parameter int unsigned LED_HOLD  = 6250000
) (
    input  logic clk,
    input  logic nReset,
    input  logic oe_i,
    input  logic data_i,
    input  logic rb_i,
    input  logic err_clr_i,
    output logic out_o,
    output logic dir_o,
    output logic led_o,
    output logic fault_o
);

    localparam int unsigned TW = ibpl_cw(TURN_CYC);
    localparam int unsigned PW = ibpl_cw(MIN_PULSE);
    localparam int unsigned FW = ibpl_cw(FB_CYC + 1);
    localparam int unsigned LW = ibpl_cw(LED_HOLD);

    localparam logic [TW-1:0] T_LOAD = TW'(TURN_CYC - 1);
    localparam logic [PW-1:0] P_LOAD = PW'(MIN_PULSE - 1);
    localparam logic [FW-1:0] F_MAX  = FW'(FB_CYC);
    localparam logic [LW-1:0] L_LOAD = LW'(LED_HOLD - 1);

    chan_state_t   state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          out_q, out_d;
    logic          prev_q;
    logic          fault_q, fault_d;

    always_comb begin : fsm
        state_d = state_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            OFF: begin
                if (oe_i) begin
                    state_d = ARM;
                    tcnt_d  = T_LOAD;
                end
            end
            ARM: begin
                if (!oe_i) begin
                    state_d = DRAIN;
                    tcnt_d  = T_LOAD;
                end else if (tcnt_q == '0) begin
                    state_d = ACTIVE;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            ACTIVE: begin
                if (!oe_i) begin
                    state_d = DRAIN;
                    tcnt_d  = T_LOAD;
                end
            end
            DRAIN: begin
                if (tcnt_q == '0) begin
                    state_d = OFF;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Data is qualified by the next state so entering DRAIN zeroes out the same edge.
    always_comb begin : stretch
        pcnt_d = '0;
        out_d  = 1'b0;
        if (state_d == ACTIVE) begin
            out_d = data_i | (pcnt_q != '0);
            if (data_i && !prev_q) begin
                pcnt_d = P_LOAD;
            end else if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - PW'(1);
            end
        end
    end

    always_comb begin : supervise
        fcnt_d  = '0;
        fault_d = fault_q;
        if (state_q == ACTIVE && rb_i != out_q) begin
            fcnt_d = (fcnt_q == F_MAX) ? fcnt_q : fcnt_q + FW'(1);
        end
        if (fcnt_d == F_MAX) begin
            fault_d = 1'b1;
        end else if (err_clr_i) begin
            fault_d = 1'b0;
        end
    end

    always_comb begin : led_timer
        lcnt_d = lcnt_q;
        if (out_d && !out_q) begin
            lcnt_d = L_LOAD;
        end else if (lcnt_q != '0) begin
            lcnt_d = lcnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= OFF;
            tcnt_q  <= '0;
            pcnt_q  <= '0;
            fcnt_q  <= '0;
            lcnt_q  <= '0;
            out_q   <= 1'b0;
            prev_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            pcnt_q  <= pcnt_d;
            fcnt_q  <= fcnt_d;
            lcnt_q  <= lcnt_d;
            out_q   <= out_d;
            prev_q  <= data_i;
            fault_q <= fault_d;
        end
    end

    assign out_o   = out_q;
    assign dir_o   = (state_q != OFF);
    assign led_o   = (lcnt_q != '0) | out_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/ibpl_out_seq.sv
// Interbackplane output cardlet: six sequenced DIOB output channels plus
// module error reporting and LED/readback assembly for the blackbox.
module ibpl_out_seq
    import ibpl_pkg::*;
#(
    parameter int unsigned NUM_CH    = IBPL_NUM_CH,
    parameter int unsigned TURN_CYC  = 4,
    parameter int unsigned MIN_PULSE = 8,
    parameter int unsigned FB_CYC    = 16,
    parameter int unsigned LED_HOLD  = 6250000
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [7:0]             internal_out,
    input  logic [7:0]             output_enable,
    input  logic [7:0]             input_enable,
    input  logic                   err_clr,
    input  logic [IBPL_NUM_CH-1:0] diob_in,
    output logic [IBPL_NUM_CH-1:0] diob_out,
    output logic [IBPL_NUM_CH-1:0] diob_dir,
    output logic [7:0]             internal_in,
    output logic [7:0]             diob_led1,
    output logic [7:0]             diob_led2,
    output logic [IBPL_NUM_CH-1:0] ch_fault,
    output logic                   plugin_error
);

    logic [IBPL_NUM_CH-1:0] led;
    logic                   plugin_error_q, plugin_error_d;
    logic                   unused_hi;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ibpl_out_chan #(
            .TURN_CYC (TURN_CYC),
            .MIN_PULSE(MIN_PULSE),
            .FB_CYC   (FB_CYC),
            .LED_HOLD (LED_HOLD)
        ) u_chan (
            .clk      (clk),
            .nReset   (nReset),
            .oe_i     (output_enable[i]),
            .data_i   (internal_out[i]),
            .rb_i     (diob_in[i]),
            .err_clr_i(err_clr),
            .out_o    (diob_out[i]),
            .dir_o    (diob_dir[i]),
            .led_o    (led[i]),
            .fault_o  (ch_fault[i])
        );
    end

    // An input-enabled pin that is not output-enabled is a slot misconfiguration.
    always_comb begin
        plugin_error_d = (|(input_enable[5:0] & ~output_enable[5:0])) | (|ch_fault);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            plugin_error_q <= 1'b0;
        end else begin
            plugin_error_q <= plugin_error_d;
        end
    end

    assign plugin_error = plugin_error_q;
    assign internal_in  = {2'b00, diob_in};
    assign diob_led1    = {2'b00, diob_dir};
    assign diob_led2    = {2'b00, led};
    assign unused_hi    = ^{internal_out[7:6], output_enable[7:6], input_enable[7:6]};

endmodule

// File: tb/tb_ibpl_out_seq.sv
// Self-checking bench for ibpl_out_seq: directed scenarios plus random traffic,
// all compared against a timestamp-based reference model.
module tb_ibpl_out_seq;

    localparam int TURN = 4;
    localparam int MINP = 8;
    localparam int FB   = 16;
    localparam int LEDH = 20;
    localparam int FAR  = -1000000;

    logic       clk = 1'b0;
    logic       nReset;
    logic [7:0] internal_out, output_enable, input_enable;
    logic       err_clr;
    logic [5:0] diob_in;
    logic [5:0] diob_out, diob_dir, ch_fault;
    logic [7:0] internal_in, diob_led1, diob_led2;
    logic       plugin_error;

    always #5 clk = ~clk;

    ibpl_out_seq #(
        .NUM_CH   (6),
        .TURN_CYC (TURN),
        .MIN_PULSE(MINP),
        .FB_CYC   (FB),
        .LED_HOLD (LEDH)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .internal_out (internal_out),
        .output_enable(output_enable),
        .input_enable (input_enable),
        .err_clr      (err_clr),
        .diob_in      (diob_in),
        .diob_out     (diob_out),
        .diob_dir     (diob_dir),
        .internal_in  (internal_in),
        .diob_led1    (diob_led1),
        .diob_led2    (diob_led2),
        .ch_fault     (ch_fault),
        .plugin_error (plugin_error)
    );

    typedef enum int {M_OFF, M_ARM, M_ACT, M_DRAIN} mmode_t;

    mmode_t   mmode   [6];
    int       t_enter [6];
    int       t_rise  [6];
    int       t_orise [6];
    int       run     [6];
    bit [5:0] m_out, m_prev, m_fault;
    bit       m_pe;
    int       cyc;
    bit [5:0] inj;
    int       n_checks, n_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) begin
            mmode[i]   = M_OFF;
            t_enter[i] = FAR;
            t_rise[i]  = FAR;
            t_orise[i] = FAR;
            run[i]     = 0;
        end
        m_out   = '0;
        m_prev  = '0;
        m_fault = '0;
        m_pe    = 1'b0;
    endfunction

    // Called once per rising edge with the inputs that were applied before it.
    function automatic void model_step();
        bit [5:0] old_out = m_out;
        m_pe = (|(input_enable[5:0] & ~output_enable[5:0])) || (|m_fault);
        cyc++;
        for (int i = 0; i < 6; i++) begin
            mmode_t was = mmode[i];
            if (was == M_ACT && diob_in[i] != old_out[i]) run[i]++;
            else run[i] = 0;
            if (run[i] >= FB) m_fault[i] = 1'b1;
            else if (err_clr) m_fault[i] = 1'b0;
            case (was)
                M_OFF:   if (output_enable[i]) begin mmode[i] = M_ARM; t_enter[i] = cyc; end
                M_ARM:   if (!output_enable[i]) begin mmode[i] = M_DRAIN; t_enter[i] = cyc; end
                         else if (cyc - t_enter[i] == TURN) begin mmode[i] = M_ACT; t_enter[i] = cyc; end
                M_ACT:   if (!output_enable[i]) begin mmode[i] = M_DRAIN; t_enter[i] = cyc; end
                M_DRAIN: if (cyc - t_enter[i] == TURN) begin mmode[i] = M_OFF; t_enter[i] = cyc; end
                default: mmode[i] = M_OFF;
            endcase
            if (mmode[i] == M_ACT) begin
                if (internal_out[i] && !m_prev[i]) t_rise[i] = cyc;
                m_out[i] = internal_out[i] || (cyc - t_rise[i] < MINP);
            end else begin
                t_rise[i] = FAR;
                m_out[i]  = 1'b0;
            end
            if (m_out[i] && !old_out[i]) t_orise[i] = cyc;
            m_prev[i] = internal_out[i];
        end
    endfunction

    task automatic check_all();
        bit [5:0] dir, led;
        for (int i = 0; i < 6; i++) begin
            dir[i] = (mmode[i] != M_OFF);
            led[i] = m_out[i] || (cyc - t_orise[i] < LEDH - 1);
        end
        check_eq("diob_out", diob_out, m_out);
        check_eq("diob_dir", diob_dir, dir);
        check_eq("diob_led1", diob_led1, {2'b00, dir});
        check_eq("diob_led2", diob_led2, {2'b00, led});
        check_eq("ch_fault", ch_fault, m_fault);
        check_eq("plugin_error", plugin_error, m_pe);
        check_eq("internal_in", internal_in, {2'b00, diob_in});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        diob_in = m_out ^ inj;
    endtask

    task automatic set_inj(input bit [5:0] v);
        inj     = v;
        diob_in = m_out ^ inj;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $fatal(1);
    end

    initial begin
        int hi;
        int burst;
        n_checks      = 0;
        n_bad         = 0;
        cyc           = 0;
        inj           = '0;
        burst         = 0;
        nReset        = 1'b0;
        internal_out  = '0;
        output_enable = '0;
        input_enable  = '0;
        err_clr       = 1'b0;
        diob_in       = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out", diob_out, 0);
        check_eq("rst_dir", diob_dir, 0);
        check_eq("rst_led2", diob_led2, 0);
        check_eq("rst_fault", ch_fault, 0);
        check_eq("rst_perr", plugin_error, 0);
        nReset = 1'b1;
        tick();

        // enable sequence on channel 0
        output_enable = 8'h01;
        internal_out  = 8'h01;
        tick();
        check_eq("en_dir0", diob_dir[0], 1);
        check_eq("en_led1", diob_led1, 8'h01);
        check_eq("en_out_arm", diob_out[0], 0);
        repeat (3) begin
            tick();
            check_eq("en_out_arm", diob_out[0], 0);
        end
        tick();
        check_eq("en_out_act", diob_out[0], 1);

        // pulse stretch on channel 2
        output_enable = 8'h05;
        repeat (6) tick();
        internal_out[2] = 1'b1;
        tick();
        hi = int'(diob_out[2]);
        internal_out[2] = 1'b0;
        repeat (20) begin
            tick();
            hi += int'(diob_out[2]);
        end
        check_eq("stretch_single", hi, 8);
        internal_out[2] = 1'b1;
        tick();
        hi = int'(diob_out[2]);
        internal_out[2] = 1'b0;
        repeat (4) begin
            tick();
            hi += int'(diob_out[2]);
        end
        internal_out[2] = 1'b1;
        tick();
        hi += int'(diob_out[2]);
        internal_out[2] = 1'b0;
        repeat (25) begin
            tick();
            hi += int'(diob_out[2]);
        end
        check_eq("stretch_double", hi, 13);

        // disable mid-pulse, re-enable during drain
        check_eq("dis_pre_out", diob_out[0], 1);
        output_enable[0] = 1'b0;
        tick();
        check_eq("dis_out0", diob_out[0], 0);
        check_eq("dis_dir0", diob_dir[0], 1);
        output_enable[0] = 1'b1;
        repeat (3) begin
            tick();
            check_eq("drain_dir0", diob_dir[0], 1);
        end
        tick();
        check_eq("reen_off", diob_dir[0], 0);
        tick();
        check_eq("reen_arm", diob_dir[0], 1);

        // readback supervision on channel 3
        output_enable = 8'h0D;
        internal_out  = 8'h09;
        repeat (6) tick();
        set_inj(6'h08);
        repeat (15) tick();
        set_inj(6'h00);
        repeat (3) tick();
        check_eq("fb15_fault", ch_fault[3], 0);
        check_eq("fb15_perr", plugin_error, 0);
        set_inj(6'h08);
        repeat (16) tick();
        check_eq("fb16_fault", ch_fault[3], 1);
        check_eq("fb16_perr_lag", plugin_error, 0);
        set_inj(6'h00);
        tick();
        check_eq("fb16_perr", plugin_error, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr_fault", ch_fault[3], 0);
        tick();
        check_eq("clr_perr", plugin_error, 0);

        // configuration check
        output_enable = 8'h00;
        input_enable  = 8'h20;
        tick();
        check_eq("cfg_err", plugin_error, 1);
        output_enable = 8'h20;
        tick();
        check_eq("cfg_ok", plugin_error, 0);
        output_enable = 8'h00;
        input_enable  = 8'hC0;
        tick();
        check_eq("cfg_hi_ign", plugin_error, 0);
        input_enable = 8'h00;

        // async reset mid-ARM (ch1) and mid-stretch (ch2)
        output_enable = 8'h04;
        internal_out  = 8'h00;
        repeat (10) tick();
        internal_out[2] = 1'b1;
        output_enable   = 8'h06;
        tick();
        internal_out[2] = 1'b0;
        repeat (2) tick();
        check_eq("pre_rst_dir1", diob_dir[1], 1);
        check_eq("pre_rst_out2", diob_out[2], 1);
        #2;
        nReset = 1'b0;
        #1;
        check_eq("arst_out", diob_out, 0);
        check_eq("arst_dir", diob_dir, 0);
        check_eq("arst_led1", diob_led1, 0);
        check_eq("arst_led2", diob_led2, 0);
        check_eq("arst_perr", plugin_error, 0);
        model_reset();
        diob_in = m_out ^ inj;
        #2;
        nReset = 1'b1;
        tick();
        check_eq("rst_rearm_dir", diob_dir, 6'h06);
        check_eq("rst_rearm_out", diob_out, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) output_enable = 8'($urandom);
            if ($urandom_range(0, 31) == 0) input_enable = 8'($urandom) & output_enable;
            if ($urandom_range(0, 63) == 0) input_enable = 8'($urandom);
            internal_out = ($urandom_range(0, 3) == 0) ? 8'($urandom) : internal_out;
            err_clr = ($urandom_range(0, 19) == 0);
            if (burst == 0 && inj == '0 && $urandom_range(0, 29) == 0) begin
                burst = $urandom_range(12, 20);
                set_inj(6'(1 << $urandom_range(0, 5)));
            end else if (burst > 0) begin
                burst--;
                if (burst == 0) set_inj(6'h00);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
